// File: rtl/piso_sfl_tx_pkg.sv
// Shared definitions for the PISO left-shift transmitter: FSM state encodings
// and the default word width.
package piso_sfl_tx_pkg;

    localparam int unsigned PISO_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the PISO transmitter: clears on word accept,
// advances while enabled, flags terminal count at WIDTH-1.
module piso_bit_counter
    import piso_sfl_tx_pkg::*;
#(
    parameter int unsigned WIDTH = PISO_WIDTH_DEFAULT,
    localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_sfl_tx.sv
// Parallel-in serial-out left-shift transmitter, MSB first, with frame markers.
// Optional trailing even-parity bit enabled by defining PISO_SFL_PARITY_EN.
module piso_sfl_tx
    import piso_sfl_tx_pkg::*;
#(
    parameter int unsigned WIDTH = PISO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pi_valid,
    input  logic [WIDTH-1:0] pi_data,
    output logic             pi_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_first,
    output logic             so_last,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]     cnt;
    logic              tc;
    logic              accept;
`ifdef PISO_SFL_PARITY_EN
    logic              par_q, par_d;
`endif

    piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  ((state_q == ST_SHIFT) && !tc),
        .cnt_o (cnt),
        .tc_o  (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
`ifdef PISO_SFL_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
`ifdef PISO_SFL_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        pi_ready = 1'b0;
        so       = 1'b0;
        so_valid = 1'b0;
        so_first = 1'b0;
        so_last  = 1'b0;
`ifdef PISO_SFL_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                pi_ready = 1'b1;
            end
            ST_SHIFT: begin
                so       = shreg_q[WIDTH-1];
                so_valid = 1'b1;
                so_first = (cnt == '0);
                shreg_d  = shreg_q << 1;
                if (tc) begin
`ifdef PISO_SFL_PARITY_EN
                    state_d  = ST_PARITY;
`else
                    pi_ready = 1'b1;
                    so_last  = 1'b1;
                    state_d  = ST_IDLE;
`endif
                end
            end
`ifdef PISO_SFL_PARITY_EN
            ST_PARITY: begin
                so       = par_q;
                so_valid = 1'b1;
                so_last  = 1'b1;
                pi_ready = 1'b1;
                state_d  = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // An accept in the final bit cycle overrides the IDLE return for gapless frames.
        if (accept) begin
            shreg_d = pi_data;
            state_d = ST_SHIFT;
`ifdef PISO_SFL_PARITY_EN
            par_d   = ^pi_data;
`endif
        end
    end

    assign accept = pi_valid && pi_ready;
    assign busy   = (state_q != ST_IDLE);

endmodule
